// File: rtl/lsu_rmw_pkg.sv
// Shared definitions for the load/store unit:
// funct3 codes, FSM states and the alignment rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  function automatic logic lsu_misaligned(
    input logic [2:0] funct3,
    input logic [2:0] addr
  );
    logic m;
    m = 1'b0;
    unique case (funct3)
      F3_H, F3_HU: m = addr[0];
      F3_W, F3_WU: m = |addr[1:0];
      F3_D:        m = |addr;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Request/response handshake plus the Data_Memory port bundle.
// master = requester and memory, slave = the load/store unit.
interface lsu_rmw_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] WriteData;
  logic              memWrite;
  logic              memRead;
  logic [DATA_W-1:0] Read_Data;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, Read_Data,
    input  req_ready, resp_valid, resp_err,
    input  resp_rdata, Mem_Addr, WriteData,
    input  memWrite, memRead
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, Read_Data,
    output req_ready, resp_valid, resp_err,
    output resp_rdata, Mem_Addr, WriteData,
    output memWrite, memRead
  );
endinterface

// File: rtl/lsu_rmw_align.sv
// Lane extraction/extension for loads and byte-lane
// merge for sub-doubleword stores (little-endian).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] rbuf,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  output logic [63:0] rdata,
  output logic [63:0] merged
);

  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] mask;

  assign sh = {off, 3'b000};

  always_comb begin
    lane  = rbuf >> sh;
    rdata = '0;
    unique case (funct3)
      F3_B:    rdata = {{56{lane[7]}}, lane[7:0]};
      F3_H:    rdata = {{48{lane[15]}}, lane[15:0]};
      F3_W:    rdata = {{32{lane[31]}}, lane[31:0]};
      F3_D:    rdata = rbuf;
      F3_BU:   rdata = {56'd0, lane[7:0]};
      F3_HU:   rdata = {48'd0, lane[15:0]};
      F3_WU:   rdata = {32'd0, lane[31:0]};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    mask = '1;
    unique case (funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase
    merged = (rbuf & ~(mask << sh))
           | ((wdata & mask) << sh);
  end

endmodule

// File: rtl/lsu_rmw.sv
// RV64 load/store unit in front of Data_Memory; narrow
// stores are done as doubleword read-modify-write.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic      clk,
  input logic      reset,
  lsu_rmw_if.slave bus
);

  lsu_state_t        state, state_n;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rbuf_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              req_err;
  logic [63:0]       src;
  logic [63:0]       ext;
  logic [63:0]       merged;

  assign req_err =
    (bus.req_write ? bus.req_funct3[2]
                   : (bus.req_funct3 == 3'b111))
    | lsu_misaligned(bus.req_funct3, bus.req_addr[2:0]);

  // Extraction reads memory directly in READ so RESP data is registered.
  assign src = (state == READ) ? bus.Read_Data : rbuf_q;

  lsu_align u_align (
    .rbuf   (src),
    .wdata  (wdata_q),
    .off    (addr_q[2:0]),
    .funct3 (f3_q),
    .rdata  (ext),
    .merged (merged)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)
            state_n = RESP;
          else if (bus.req_write && bus.req_funct3 == F3_D)
            state_n = WRITE;
          else
            state_n = READ;
        end
      end
      READ:    state_n = wr_q ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        wr_q    <= bus.req_write;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == READ)
        rbuf_q <= bus.Read_Data;
      if (state_n == RESP) begin
        err_q   <= (state == IDLE);
        rdata_q <= (state == READ && !wr_q) ? ext : '0;
      end
    end
  end

  // reset gates the strobes so an in-flight write never commits
  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.memRead    = (state == READ) && !reset;
  assign bus.memWrite   = (state == WRITE) && !reset;
  assign bus.Mem_Addr   = (state == READ || state == WRITE)
                          ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus.WriteData  = (state == WRITE)
                          ? ((f3_q == F3_D) ? wdata_q : merged)
                          : '0;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;

endmodule
